// File: rtl/dac_pkg.sv
// dac_pkg: shared constants, request-type and state enums for the DAC update engine
package dac_pkg;
    localparam int NUM_CH = 24;
    localparam int DAC_W = 12;
    localparam int CH_PER_CHIP = 8;
    localparam int NUM_CHIPS = 3;
    localparam int FRAME_W = 16;
    typedef enum logic [1:0] {REQ_NONE, REQ_SINGLE, REQ_BULK} req_t;
    typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_SEND, ST_LDAC, ST_DONE} state_t;
    typedef enum logic [2:0] {SP_IDLE, SP_SETUP, SP_SHIFT, SP_HOLD, SP_GAP} spi_state_t;
endpackage

// File: rtl/dac_spi_shifter.sv
// dac_spi_shifter: sends one 16-bit SPI frame (CS setup, shift, CS hold, inter-frame gap)
//   start     : in  - begin a frame; frame/chip are captured on this cycle
//   frame     : in  - frame word, sent MSB first
//   chip      : in  - index of the chip select to drive low
//   spi_*     : out - SCLK (CPOL=0), MOSI, per-chip active-low selects
//   done      : out - one-cycle pulse in the last GAP cycle
module dac_spi_shifter
    import dac_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int CS_GAP = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [FRAME_W-1:0]   frame,
    input  logic [1:0]           chip,
    output logic                 spi_sclk,
    output logic                 spi_mosi,
    output logic [NUM_CHIPS-1:0] spi_cs_n,
    output logic                 done
);
    localparam int CW = 16;
    spi_state_t state, state_nx;
    logic [CW-1:0] cnt;
    logic [4:0] half;
    logic [FRAME_W-1:0] sreg;
    logic tick, gap_end;
    assign tick = cnt == CW'(CLK_DIV - 1);
    assign gap_end = cnt == CW'(CS_GAP - 1);
    assign done = state == SP_GAP && gap_end;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= SP_IDLE;
        else state <= state_nx;
    always_comb begin
        state_nx = state;
        case (state)
            SP_IDLE:  state_nx = start ? SP_SETUP : SP_IDLE;
            SP_SETUP: state_nx = tick ? SP_SHIFT : SP_SETUP;
            SP_SHIFT: state_nx = tick && &half ? SP_HOLD : SP_SHIFT;
            SP_HOLD:  state_nx = tick ? SP_GAP : SP_HOLD;
            SP_GAP:   state_nx = gap_end ? SP_IDLE : SP_GAP;
            default:  state_nx = SP_IDLE;
        endcase
    end
    // SHIFT spans 32 half-periods: SCLK rises on entry, then toggles every CLK_DIV cycles;
    // MOSI advances on each falling edge so it is stable across the following rise.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            cnt <= '0;
            half <= '0;
            sreg <= '0;
            spi_sclk <= 1'b0;
            spi_mosi <= 1'b0;
            spi_cs_n <= '1;
        end else begin
            cnt <= (state == SP_IDLE || state_nx != state || (state == SP_SHIFT && tick)) ? '0 : cnt + 1'b1;
            spi_sclk <= state_nx == SP_SHIFT && (state == SP_SETUP || (spi_sclk ^ tick));
            if (state == SP_IDLE && start) begin
                sreg <= frame;
                spi_mosi <= frame[FRAME_W-1];
                half <= '0;
                spi_cs_n <= ~(NUM_CHIPS'(1) << chip);
            end
            if (state == SP_SHIFT && tick) begin
                half <= half + 1'b1;
                if (spi_sclk) begin
                    sreg <= sreg << 1;
                    spi_mosi <= sreg[FRAME_W-2];
                end
            end
            if (state == SP_HOLD && tick) spi_cs_n <= '1;
        end
endmodule

// File: rtl/dac_update_engine.sv
// dac_update_engine: accepts single/bulk DAC updates, sends SPI frames to three 8-ch DACs, pulses LDAC
//   all_channel_data/target_channel/single_dac_value : in  - update payloads
//   update_single_channel/update_all_channels        : in  - request pulses (bulk wins)
//   dac_busy/update_complete                         : out - handshake to the command manager
//   total_updates/last_update_time/mode_switches     : out - status counters
//   spi_sclk/spi_mosi/spi_cs_n/dac_ldac_n            : out - DAC interface
//   DAC_LDAC_EN: when defined, frames only load input registers and an LDAC pulse updates all outputs
module dac_update_engine
    import dac_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int CS_GAP = 2,
    parameter int LDAC_W = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH*DAC_W-1:0] all_channel_data,
    input  logic [4:0]              target_channel,
    input  logic [DAC_W-1:0]        single_dac_value,
    input  logic                    update_single_channel,
    input  logic                    update_all_channels,
    output logic                    dac_busy,
    output logic                    update_complete,
    output logic [31:0]             total_updates,
    output logic [15:0]             last_update_time,
    output logic [3:0]              mode_switches,
    output logic                    spi_sclk,
    output logic                    spi_mosi,
    output logic [NUM_CHIPS-1:0]    spi_cs_n,
    output logic                    dac_ldac_n
);
`ifdef DAC_LDAC_EN
    localparam logic MODE_BIT = 1'b0;
    localparam state_t AFTER_LAST = ST_LDAC;
`else
    localparam logic MODE_BIT = 1'b1;
    localparam state_t AFTER_LAST = ST_DONE;
`endif
    state_t state, state_nx;
    req_t cur_type, new_type;
    logic [NUM_CH*DAC_W-1:0] shadow;
    logic [4:0] s_ch, idx, ch;
    logic [DAC_W-1:0] s_val, val;
    logic [15:0] elapsed, lcnt;
    logic acc_bulk, acc_single, accept, last_frame, frame_done;
    assign acc_bulk = state == ST_IDLE && update_all_channels;
    assign acc_single = state == ST_IDLE && !update_all_channels && update_single_channel
                        && target_channel < 5'(NUM_CH);
    assign accept = acc_bulk || acc_single;
    assign new_type = acc_bulk ? REQ_BULK : REQ_SINGLE;
    assign ch = cur_type == REQ_BULK ? idx : s_ch;
    assign val = cur_type == REQ_BULK ? shadow[idx*DAC_W +: DAC_W] : s_val;
    assign last_frame = cur_type != REQ_BULK || idx == 5'(NUM_CH - 1);
    assign dac_busy = state != ST_IDLE;
    assign update_complete = state == ST_DONE;
`ifdef DAC_LDAC_EN
    assign dac_ldac_n = state != ST_LDAC;
`else
    assign dac_ldac_n = 1'b1;
`endif
    dac_spi_shifter #(.CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP)) u_shifter (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (state == ST_LOAD),
        .frame    ({MODE_BIT, 3'(ch % 5'(CH_PER_CHIP)), val}),
        .chip     (2'(ch / 5'(CH_PER_CHIP))),
        .spi_sclk (spi_sclk),
        .spi_mosi (spi_mosi),
        .spi_cs_n (spi_cs_n),
        .done     (frame_done)
    );
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= ST_IDLE;
        else state <= state_nx;
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: state_nx = accept ? ST_LOAD : ST_IDLE;
            ST_LOAD: state_nx = ST_SEND;
            ST_SEND: state_nx = !frame_done ? ST_SEND : last_frame ? AFTER_LAST : ST_LOAD;
            ST_LDAC: state_nx = lcnt == 16'(LDAC_W - 1) ? ST_DONE : ST_LDAC;
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end
    // elapsed holds the 1-based cycle number since accept, so in DONE it equals N
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            cur_type <= REQ_NONE;
            s_ch <= '0;
            s_val <= '0;
            idx <= '0;
            elapsed <= '0;
            lcnt <= '0;
            total_updates <= '0;
            last_update_time <= '0;
            mode_switches <= '0;
        end else begin
            if (accept) begin
                cur_type <= new_type;
                if (cur_type != REQ_NONE && cur_type != new_type) mode_switches <= mode_switches + 1'b1;
                s_ch <= target_channel;
                s_val <= single_dac_value;
                idx <= '0;
                elapsed <= 16'd1;
            end else if (dac_busy && elapsed != 16'hFFFF) elapsed <= elapsed + 1'b1;
            if (state == ST_SEND && frame_done && !last_frame) idx <= idx + 1'b1;
            lcnt <= state == ST_LDAC ? lcnt + 1'b1 : '0;
            if (update_complete) begin
                total_updates <= total_updates + 1'b1;
                last_update_time <= elapsed;
            end
        end
    always_ff @(posedge clk)
        if (acc_bulk) shadow <= all_channel_data;
endmodule

// File: doc/dac_update_engine.md
# dac_update_engine

Downstream consumer of the DAC command manager: accepts single-channel and all-channel update requests, serializes them as 16-bit SPI frames to three 8-channel 12-bit DAC chips, then latches the outputs with an LDAC pulse. Drives the `dac_busy`/`update_complete` handshake back to the command manager. Also maintains the status counters the command manager reports.

## Interface
- `CLK_DIV`, 4: `clk` cycles per SCLK half-period; must be ≥2.
- `CS_GAP`, 2: `clk` cycles that all `spi_cs_n` stay high between frames; must be ≥1.
- `LDAC_W`, 2: width of the `dac_ldac_n` low pulse in `clk` cycles; must be ≥1.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `all_channel_data` in 288: channel i = `[i*12 +: 12]`.
- `target_channel` in 5: single-update channel, 0–23.
- `single_dac_value` in 12: single-update value.
- `update_single_channel` in 1: single-update request pulse.
- `update_all_channels` in 1: bulk-update request pulse.
- `dac_busy` out 1: request accepted and not yet finished.
- `update_complete` out 1: one-cycle completion pulse.
- `total_updates` out 32: completed updates; wraps.
- `last_update_time` out 16: cycles from accept to complete for the last update; saturates at 16'hFFFF.
- `mode_switches` out 4: request-type changes; wraps.
- `spi_sclk` out 1: SPI clock, CPOL=0.
- `spi_mosi` out 1: SPI data, MSB first.
- `spi_cs_n` out 3: per-chip select, active-low.
- `dac_ldac_n` out 1: DAC latch strobe, active-low.

## Operation
**Reset values**
- All counters, `dac_busy` and `update_complete` reset to 0.
- `spi_sclk` = 0, `spi_mosi` = 0, `spi_cs_n` = 3'b111, `dac_ldac_n` = 1.
- Previous request type resets to NONE.

**Accepting requests**
- A request is accepted only in IDLE. On accept:
  - Capture the payload into a shadow register: all 288 bits, or channel + value.
  - `dac_busy` goes high on the accept edge.
- If both request inputs are high in the same cycle, the bulk request wins.
- Requests that arrive while busy are dropped with no side effect. This includes the repeat pulses the command manager issues before it sees `dac_busy`.
- A single request with `target_channel` ≥ 24 is dropped: no busy, no complete, no counter change.

**Frame mapping**
- Channel ch goes to chip ch/8 (selects `spi_cs_n[ch/8]`) at address ch%8.
- Frame = {mode bit, addr[2:0], value[11:0]}.
- Mode bit: 0 = write input register only; 1 = write and update output.
- A bulk update sends channels 0..23 in ascending order.

**State machine**
- IDLE → LOAD (1 cycle: select frame, assert chip select).
- CS_SETUP (CLK_DIV cycles).
- SHIFT (32·CLK_DIV cycles, 16 bits). `spi_mosi` changes on SCLK falling edges; the first bit is valid from CS_SETUP entry.
- CS_HOLD (CLK_DIV cycles, `spi_sclk` low).
- GAP (CS_GAP cycles, all chip selects high).
- After GAP: go to LOAD if frames remain, otherwise LDAC (LDAC_W cycles, `dac_ldac_n` = 0).
- DONE (1 cycle) → IDLE.

**Completion (in DONE)**
- `update_complete` = 1 and `dac_busy` is still 1. `dac_busy` falls on the exit edge.
- `total_updates` increments by 1.
- `last_update_time` loads the elapsed cycle count.

**mode_switches**
- Increments at accept when the accepted type differs from the previous accepted type.
- The first request after reset never counts.

## Timing
- Per-frame cycles P = 1 + 34·CLK_DIV + CS_GAP, which is 139 at defaults.
- `update_complete` is asserted in cycle N after the accept edge, counting the cycle after accept as cycle 1:
  - N = F·P + LDAC_W + 1, with F = 1 for single and F = 24 for bulk.
  - Defaults: single 142, bulk 3339.
- `last_update_time` = N, saturating.
- A new request can be accepted on the first cycle back in IDLE, i.e. the cycle after `update_complete`.
- An asynchronous reset mid-frame immediately forces all outputs to their reset values and aborts the frame. No completion pulse is produced.

## Configuration
- `DAC_LDAC_EN` defined:
  - Frames use mode bit 0.
  - The LDAC state issues the `dac_ldac_n` pulse, so all channels change simultaneously.
- `DAC_LDAC_EN` undefined:
  - Frames use mode bit 1.
  - The LDAC state is skipped and `dac_ldac_n` is held at 1.
  - N = F·P + 1, giving defaults of single 140 and bulk 3337.

## Structure
- Package `dac_pkg` holds:
  - Constants: NUM_CH = 24, DAC_W = 12, CH_PER_CHIP = 8, NUM_CHIPS = 3, FRAME_W = 16.
  - The request-type enum (NONE, SINGLE, BULK).
  - The state enum.
- Sub-module `dac_spi_shifter` handles one frame:
  - Inputs: `start`, `frame[15:0]`, `chip[1:0]`.
  - Outputs: `spi_sclk`/`spi_mosi`/`spi_cs_n`, and a `done` pulse at the end of GAP.
  - It owns the CS_SETUP/SHIFT/CS_HOLD/GAP timing.
- The top level owns request arbitration, frame sequencing, LDAC, DONE and the counters.

## Test plan
- Single update, ch 10, value 0xABC, `DAC_LDAC_EN` defined: `spi_cs_n` = 3'b101; MOSI frame 0x2ABC; 2-cycle LDAC pulse; `update_complete` at cycle 142; `last_update_time` = 142; `total_updates` = 1.
- Bulk update with ch i = i·0x101: 24 frames ch0..ch23; chip select rotates chip0→1→2 every 8 frames; frame 23 = 0x7717; complete at cycle 3339.
- Both requests in the same cycle, then repeat pulses while busy: exactly one bulk update and one completion.
- Single ch 30: no busy, no SPI activity, counters unchanged.
- Sequence single, single, bulk, single: `mode_switches` = 2; `total_updates` = 4.
- Reset asserted mid-SHIFT: `spi_cs_n` = 3'b111, `dac_busy` = 0 and counters = 0 within the reset; the next request completes normally.
